// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: grant codes, slave codes, arbiter state encoding
// and the grant-code decode used by the arbiter output register.
package bus_arbiter_pkg;

  // Bus mux grant codes
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_M1   = 2'd1;
  localparam logic [1:0] GNT_M2   = 2'd2;

  // Bus mux slave codes
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_S1   = 2'd1;
  localparam logic [1:0] SEL_S2   = 2'd2;
  localparam logic [1:0] SEL_S3   = 2'd3;

  // Hold counter width; covers the full legal TIMEOUT range (2..255)
  localparam int HOLD_W = 8;

  // Arbiter states; TURN is the one-cycle bus turnaround
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GNT_M1 = 2'd1,
    ST_GNT_M2 = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  // Master that most recently received the bus
  typedef enum logic {
    LAST_M1 = 1'b0,
    LAST_M2 = 1'b1
  } master_e;

  // Grant code presented to the bus mux for a given state (never 3)
  function automatic logic [1:0] grant_code(input arb_state_e s);
    logic [1:0] code;
    code = GNT_NONE;
    case (s)
      ST_GNT_M1: code = GNT_M1;
      ST_GNT_M2: code = GNT_M2;
      default:   code = GNT_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Grant hold counter: counts cycles while the current owner keeps the bus,
// clears otherwise, and saturates at TIMEOUT-1 where it raises terminal.
module arb_hold_timer
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic terminal
);

  localparam logic [HOLD_W-1:0] TERM = HOLD_W'(TIMEOUT - 1);

  logic [HOLD_W-1:0] count;

  // Count grant cycles; restart whenever the owner is not being held over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!hold) begin
      count <= '0;
    end else if (count != TERM) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERM);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with alternating tie-break, slave-select latching,
// a one-cycle turnaround between owners and a forced release after TIMEOUT
// grant cycles when the other master is waiting. All outputs are registered.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_breq,
  input  logic [1:0] m1_slave_sel,
  input  logic       m2_breq,
  input  logic [1:0] m2_slave_sel,
  output logic [1:0] bus_grant,
  output logic [1:0] slave_sel,
  output logic       m1_bgrant,
  output logic       m2_bgrant,
  output logic       arb_timeout
);

  arb_state_e state;
  arb_state_e next_state;
  master_e    last_grant;
  logic       m1_elig;
  logic       m2_elig;
  logic       force_rel;
  logic       hold;
  logic       hold_term;

  // A request without a target slave is not a request
  assign m1_elig = m1_breq && (m1_slave_sel != SEL_NONE);
  assign m2_elig = m2_breq && (m2_slave_sel != SEL_NONE);

  // Counter keeps running only while the current owner stays granted
  assign hold = ((state == ST_GNT_M1) || (state == ST_GNT_M2)) &&
                (next_state == state);

  arb_hold_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .terminal (hold_term)
  );

  // Next-state selection; a voluntary release takes priority over a forced one
  always_comb begin
    next_state = state;
    force_rel  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m1_elig && m2_elig) begin
          next_state = (last_grant == LAST_M2) ? ST_GNT_M1 : ST_GNT_M2;
        end else if (m1_elig) begin
          next_state = ST_GNT_M1;
        end else if (m2_elig) begin
          next_state = ST_GNT_M2;
        end
      end
      ST_GNT_M1: begin
        if (!m1_breq) begin
          next_state = ST_TURN;
        end else if (hold_term && m2_elig) begin
          next_state = ST_TURN;
          force_rel  = 1'b1;
        end
      end
      ST_GNT_M2: begin
        if (!m2_breq) begin
          next_state = ST_TURN;
        end else if (hold_term && m1_elig) begin
          next_state = ST_TURN;
          force_rel  = 1'b1;
        end
      end
      ST_TURN: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // State register and fairness memory; last_grant moves on grant entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= LAST_M2;
    end else begin
      state <= next_state;
      if ((next_state == ST_GNT_M1) && (state != ST_GNT_M1)) begin
        last_grant <= LAST_M1;
      end else if ((next_state == ST_GNT_M2) && (state != ST_GNT_M2)) begin
        last_grant <= LAST_M2;
      end
    end
  end

  // Registered mux controls; slave_sel is captured once at grant entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_grant   <= GNT_NONE;
      slave_sel   <= SEL_NONE;
      m1_bgrant   <= 1'b0;
      m2_bgrant   <= 1'b0;
      arb_timeout <= 1'b0;
    end else begin
      bus_grant   <= grant_code(next_state);
      m1_bgrant   <= (next_state == ST_GNT_M1);
      m2_bgrant   <= (next_state == ST_GNT_M2);
      arb_timeout <= force_rel;
      case (next_state)
        ST_GNT_M1: slave_sel <= (state == ST_GNT_M1) ? slave_sel : m1_slave_sel;
        ST_GNT_M2: slave_sel <= (state == ST_GNT_M2) ? slave_sel : m2_slave_sel;
        default:   slave_sel <= SEL_NONE;
      endcase
    end
  end

endmodule
